// File: rtl/mor1kx_bp_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mor1kx_bp_table_arbiter
// Description : Access controller for the single-port table of 2-bit
//               saturating branch-prediction counters.
//               - After reset, or when clear_i is pulsed, it walks every
//                 table entry and writes INIT_VALUE to it.
//               - It shares the table port between decode-stage prediction
//                 reads and resolve-stage counter updates.
//               - Updates wait in a small FIFO until the port is free.
//               - A full FIFO takes priority over reads.
// Revision    : 1.0 - initial release
//
// Optional feature (compile-time macro):
//   MOR1KX_BP_UPDQ_FWD_EN - a granted read whose index matches a queued
//                           update returns the youngest queued value
//                           instead of the stale table contents.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             restart the clear walk and flush the update queue
//   init_busy_o         clear walk in progress
//   rd_req_i/rd_idx_i   prediction read request and index
//   rd_gnt_o            read granted this cycle (combinational)
//   rd_valid_o          read data valid, one cycle after grant
//   rd_data_o           counter value of the granted read
//   predicted_flag_o    MSB of rd_data_o (predict taken)
//   upd_valid_i/...     resolved-branch update: index, old counter, outcome
//   upd_ready_o         queue accepts an update this cycle
//   tbl_*               single-port table SRAM interface (1-cycle read)
// ============================================================================
module mor1kx_bp_table_arbiter #(
    parameter int          TABLE_AW   = 7,
    parameter int          UPDQ_AW    = 2,
    parameter logic [1:0]  INIT_VALUE = 2'b01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    output logic                init_busy_o,
    input  logic                rd_req_i,
    input  logic [TABLE_AW-1:0] rd_idx_i,
    output logic                rd_gnt_o,
    output logic                rd_valid_o,
    output logic [1:0]          rd_data_o,
    output logic                predicted_flag_o,
    input  logic                upd_valid_i,
    input  logic [TABLE_AW-1:0] upd_idx_i,
    input  logic [1:0]          upd_cnt_i,
    input  logic                upd_taken_i,
    output logic                upd_ready_o,
    output logic                tbl_en_o,
    output logic                tbl_we_o,
    output logic [TABLE_AW-1:0] tbl_addr_o,
    output logic [1:0]          tbl_wdata_o,
    input  logic [1:0]          tbl_rdata_i
);

    localparam int                  c_depth     = 1 << UPDQ_AW;
    localparam logic [TABLE_AW-1:0] c_walk_last = '1;
    localparam logic [UPDQ_AW:0]    c_full_cnt  = (UPDQ_AW+1)'(c_depth);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [TABLE_AW-1:0] r_walk;

    // Update queue: circular buffer plus occupancy counter.
    logic [TABLE_AW-1:0] r_q_idx [c_depth];
    logic [1:0]          r_q_val [c_depth];
    logic [UPDQ_AW-1:0]  r_wr_ptr;
    logic [UPDQ_AW-1:0]  r_rd_ptr;
    logic [UPDQ_AW:0]    r_count;

    logic                r_rd_valid;

    logic                w_run;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_rd_gnt;
    logic [1:0]          w_next_val;

    // ------------------------------------------------------------------
    // Status and arbitration
    // ------------------------------------------------------------------
    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // A full queue must drain before it can accept new updates. A pop in
    // the same cycle therefore does not open a slot.
    assign upd_ready_o = w_run & ~w_full;

    // A clear cycle takes no update. The queue is flushed anyway.
    assign w_push = upd_valid_i & upd_ready_o & ~clear_i;

    // Head write: forced when full, else only when no read wants the port.
    // In a clear cycle the head is discarded rather than written, because
    // the walk will overwrite the table anyway.
    assign w_pop    = w_run & ~clear_i & (w_full | (~rd_req_i & ~w_empty));
    assign w_rd_gnt = w_run & ~w_full & rd_req_i;

    assign rd_gnt_o = w_rd_gnt;

    // Saturating next counter value, stored at enqueue time.
    always_comb begin
        w_next_val = upd_cnt_i;
        if (upd_taken_i) begin
            if (upd_cnt_i != 2'b11) begin
                w_next_val = upd_cnt_i + 2'b01;
            end
        end else begin
            if (upd_cnt_i != 2'b00) begin
                w_next_val = upd_cnt_i - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table port mux
    // ------------------------------------------------------------------
    always_comb begin
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = '0;
        tbl_wdata_o = 2'b00;
        if (r_state == ST_INIT) begin
            tbl_en_o    = 1'b1;
            tbl_we_o    = 1'b1;
            tbl_addr_o  = r_walk;
            tbl_wdata_o = INIT_VALUE;
        end else if (w_pop) begin
            tbl_en_o    = 1'b1;
            tbl_we_o    = 1'b1;
            tbl_addr_o  = r_q_idx[r_rd_ptr];
            tbl_wdata_o = r_q_val[r_rd_ptr];
        end else if (w_rd_gnt) begin
            tbl_en_o    = 1'b1;
            tbl_addr_o  = rd_idx_i;
        end
    end

    // ------------------------------------------------------------------
    // Clear-walk FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_walk  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (clear_i) begin
                        r_walk <= '0;
                    end else if (r_walk == c_walk_last) begin
                        r_state <= ST_RUN;
                        r_walk  <= '0;
                    end else begin
                        r_walk <= r_walk + TABLE_AW'(1);
                    end
                end
                ST_RUN: begin
                    if (clear_i) begin
                        r_state <= ST_INIT;
                        r_walk  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_walk  <= '0;
                end
            endcase
        end
    end

    assign init_busy_o = (r_state == ST_INIT);

    // ------------------------------------------------------------------
    // Update queue control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + UPDQ_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + UPDQ_AW'(1);
            end
            r_count <= r_count + {{UPDQ_AW{1'b0}}, w_push}
                               - {{UPDQ_AW{1'b0}}, w_pop};
        end
    end

    // Queue payload needs no reset: the count marks which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= upd_idx_i;
            r_q_val[r_wr_ptr] <= w_next_val;
        end
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_gnt;
        end
    end

    assign rd_valid_o = r_rd_valid;

`ifdef MOR1KX_BP_UPDQ_FWD_EN
    logic       w_fwd_hit;
    logic [1:0] w_fwd_val;
    logic       r_fwd_hit;
    logic [1:0] r_fwd_val;

    // The scan runs oldest to youngest, so the last match wins and the
    // youngest queued value is used. An entry pushed in the grant cycle
    // is not yet counted in r_count, so it is not compared.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_val = 2'b00;
        for (int i = 0; i < c_depth; i++) begin
            if (((UPDQ_AW+1)'(i) < r_count) &&
                (r_q_idx[r_rd_ptr + UPDQ_AW'(i)] == rd_idx_i)) begin
                w_fwd_hit = 1'b1;
                w_fwd_val = r_q_val[r_rd_ptr + UPDQ_AW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_hit <= 1'b0;
            r_fwd_val <= 2'b00;
        end else if (w_rd_gnt) begin
            r_fwd_hit <= w_fwd_hit;
            r_fwd_val <= w_fwd_val;
        end
    end

    assign rd_data_o = !r_rd_valid ? 2'b00 :
                       (r_fwd_hit ? r_fwd_val : tbl_rdata_i);
`else
    // Gate with valid so the output is 0 when no read result is present.
    assign rd_data_o = r_rd_valid ? tbl_rdata_i : 2'b00;
`endif

    assign predicted_flag_o = rd_data_o[1];

endmodule
`default_nettype wire

// File: doc/mor1kx_bp_table_arbiter.md
# mor1kx_bp_table_arbiter

Controller for the single-port 2-bit saturating-counter table used by the branch predictors. It clears the table after reset or on request. It shares the table port between decode-stage prediction reads and resolve-stage counter updates, holding updates in a small queue. It sits between the predictor front end (decode/execute) and the table SRAM.

## Interface
Parameters:
- TABLE_AW, 7, table index width; the table has 2^TABLE_AW entries.
- UPDQ_AW, 2, update-queue depth log2 (4 entries).
- INIT_VALUE, 2'b01, counter value written by the clear walk (weakly not-taken).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  restart the clear walk and flush the update queue.
- init_busy_o  out  1  clear walk in progress.
- rd_req_i  in  1  prediction read request.
- rd_idx_i  in  TABLE_AW  index to read.
- rd_gnt_o  out  1  read granted this cycle (combinational).
- rd_valid_o  out  1  read data valid (registered).
- rd_data_o  out  2  counter value for the granted read.
- predicted_flag_o  out  1  equals rd_data_o[1].
- upd_valid_i  in  1  resolved-branch update offered.
- upd_idx_i  in  TABLE_AW  index to update.
- upd_cnt_i  in  2  counter value returned with the original prediction.
- upd_taken_i  in  1  real outcome (1 = taken).
- upd_ready_o  out  1  queue accepts an update this cycle.
- tbl_en_o, tbl_we_o  out  1 each  table port enable and write enable.
- tbl_addr_o  out  TABLE_AW  table address.
- tbl_wdata_o  out  2  table write data.
- tbl_rdata_i  in  2  table read data, valid one cycle after a read enable.

## Operation
- FSM states: INIT and RUN. Reset enters INIT with the walk counter at 0.
- INIT:
  - Each cycle writes INIT_VALUE to address = walk counter, then increments the counter.
  - Leaves for RUN after writing address 2^TABLE_AW-1.
  - rd_gnt_o=0 and upd_ready_o=0 throughout.
- RUN:
  - clear_i goes to INIT with walk counter 0 and empties the queue; any entry dequeued that same cycle is discarded.
  - clear_i asserted during INIT restarts the walk at 0.
- Update acceptance:
  - Enqueue when upd_valid_i & upd_ready_o. upd_ready_o = RUN & !full.
  - An update offered while not ready is dropped (updates are hints).
  - When the queue is full, a same-cycle pop does not free a slot for enqueue.
- Queued value:
  - A new entry stores idx and the saturated next value: taken ? min(cnt+1,3) : max(cnt-1,0).
- Port arbitration in RUN, one access per cycle:
  - If the queue is full, the head update wins and rd_gnt_o=0.
  - Otherwise a read wins if rd_req_i is asserted.
  - Otherwise the queue head is written if the queue is non-empty.
  - Otherwise the port is idle with tbl_en_o=0.
- Write:
  - tbl_en_o=1, tbl_we_o=1, addr/wdata taken from the queue head.
  - The head pops in the same cycle.
- Read:
  - tbl_en_o=1, tbl_we_o=0, tbl_addr_o=rd_idx_i.
- Stale counter values:
  - No read-modify-write is done. Two in-flight branches to the same index may each write a value computed from the same old counter. This is accepted.

## Timing
- Reset values:
  - rd_valid_o=0, rd_data_o=0, init_busy_o=1, queue empty, walk counter 0.
  - rd_gnt_o=0 and upd_ready_o=0.
- Clear walk duration:
  - Takes exactly 2^TABLE_AW cycles after rst_n deassertion (or after a clear_i cycle).
  - init_busy_o falls on the edge after the last write; RUN begins at cycle 2^TABLE_AW.
- Read latency:
  - rd_gnt_o is asserted in cycle N.
  - rd_valid_o=1 with rd_data_o in cycle N+1, for one cycle.
- Update latency:
  - An update enqueued in cycle N can be written no earlier than cycle N+1.
  - An enqueued update waits while reads win and the queue is not full.
- Reset asserted mid-operation:
  - Immediately clears the queue and rd_valid_o.
  - Forces INIT; the clear walk restarts on rst_n release.

## Configuration
- MOR1KX_BP_UPDQ_FWD_EN defined:
  - At grant, rd_idx_i is compared against all valid queue entries.
  - On a match, rd_data_o in N+1 is the youngest matching entry's stored value instead of tbl_rdata_i.
  - An entry enqueued in the grant cycle itself is not compared.
- Not defined:
  - rd_data_o is always tbl_rdata_i; no comparators are built.

## Test plan
- Reset release with TABLE_AW=7:
  - init_busy_o=1 for 128 cycles with tbl_we_o=1 and addresses 0..127 in order, wdata 2'b01.
  - Then init_busy_o=0.
- Update then read, idx 5:
  - Enqueue upd_cnt_i=3, taken=1, followed by idle cycles.
  - Table write at idx 5 with value 3 (saturation).
  - Later read of idx 5 gives rd_data_o=3 and predicted_flag_o=1 one cycle after grant.
- Queue pressure:
  - rd_req_i held high while 4 updates are enqueued.
  - upd_ready_o=0 once full.
  - The next cycle has rd_gnt_o=0 and a head write; upd_ready_o returns to 1 after the pop.
- Forwarding with MOR1KX_BP_UPDQ_FWD_EN:
  - Enqueue idx 9 cnt=1 taken=0 (stored 0), then read idx 9 while the entry is still queued.
  - rd_data_o=0.
  - Without the macro, rd_data_o shows the table content (1 after init).
- clear_i in RUN with 2 queued updates:
  - Queue empties and a 128-cycle walk restarts at address 0.
  - No queued write ever appears on the port.
- rst_n pulsed low mid-read:
  - rd_valid_o=0 during reset.
  - Walk restarts from address 0 after release.
